// File: rtl/target_box_detect.sv
// target_box_detect: per-frame bounding box of foreground mask pixels, published at each frame start
module target_box_detect #(
    parameter int MIN_PIXELS = 64,
    parameter int CW         = 12
) (
    input  logic          pixelclk,
    input  logic          reset_n,
    input  logic          i_mask,
    input  logic          i_hsync,
    input  logic          i_vsync,
    input  logic          i_de,
    output logic [CW-1:0] hcount_l,
    output logic [CW-1:0] hcount_r,
    output logic [CW-1:0] vcount_l,
    output logic [CW-1:0] vcount_r,
    output logic          box_valid,
    output logic [19:0]   pix_cnt,
    output logic          frame_done
);
    typedef enum logic {IDLE, ACCUM} state_t;
    state_t        r_state, w_next;
    logic          r_vs_d, r_de_d;
    logic [CW-1:0] r_h_cnt, r_v_cnt;
    logic [CW-1:0] r_min_h, r_max_h, r_min_v, r_max_v;
    logic [19:0]   r_acc_cnt;
    logic          w_vs_rise, w_de_fall, w_accum, w_close, w_qualify;
    logic          w_unused_hsync;
    assign w_unused_hsync = i_hsync;
    assign w_vs_rise = i_vsync & ~r_vs_d;
    assign w_de_fall = ~i_de & r_de_d;
    assign w_qualify = (r_acc_cnt >= 20'(MIN_PIXELS)) && (r_min_h < r_max_h) && (r_min_v < r_max_v);
    // sync edge delays and raster position counters
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_d  <= 1'b0;
            r_de_d  <= 1'b0;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_vs_d  <= i_vsync;
            r_de_d  <= i_de;
            r_h_cnt <= !i_de ? '0 : (r_h_cnt == '1) ? r_h_cnt : r_h_cnt + CW'(1);
            r_v_cnt <= w_vs_rise ? '0 : (w_de_fall && r_v_cnt != '1) ? r_v_cnt + CW'(1) : r_v_cnt;
        end
    end
    // FSM state register
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end
    // next state; the first frame after reset is only a sync point and is discarded
    always_comb begin
        w_next  = r_state;
        w_accum = 1'b0;
        w_close = 1'b0;
        if (r_state == IDLE) begin
            w_next = w_vs_rise ? ACCUM : IDLE;
        end else begin
            w_close = w_vs_rise;
            w_accum = i_de & i_mask & ~w_vs_rise;
        end
    end
    // running extent and count of foreground pixels in the current frame
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n || w_close) begin
            r_min_h   <= '1;
            r_max_h   <= '0;
            r_min_v   <= '1;
            r_max_v   <= '0;
            r_acc_cnt <= '0;
        end else if (w_accum) begin
            r_min_h   <= (r_h_cnt < r_min_h) ? r_h_cnt : r_min_h;
            r_max_h   <= (r_h_cnt > r_max_h) ? r_h_cnt : r_max_h;
            r_min_v   <= (r_v_cnt < r_min_v) ? r_v_cnt : r_min_v;
            r_max_v   <= (r_v_cnt > r_max_v) ? r_v_cnt : r_max_v;
            r_acc_cnt <= (r_acc_cnt == '1) ? r_acc_cnt : r_acc_cnt + 20'd1;
        end
    end
    // publish the closed frame's result; a non-qualifying box reads as all zeros
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            hcount_l   <= '0;
            hcount_r   <= '0;
            vcount_l   <= '0;
            vcount_r   <= '0;
            box_valid  <= 1'b0;
            pix_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_close;
            if (w_close) begin
                hcount_l  <= w_qualify ? r_min_h : '0;
                hcount_r  <= w_qualify ? r_max_h : '0;
                vcount_l  <= w_qualify ? r_min_v : '0;
                vcount_r  <= w_qualify ? r_max_v : '0;
                box_valid <= w_qualify;
                pix_cnt   <= r_acc_cnt;
            end
        end
    end
endmodule

// File: tb/tb_target_box_detect.sv
// tb_target_box_detect: directed frame scenarios for target_box_detect
module tb_target_box_detect;
    localparam int CW = 12;
    localparam int OW = 4*CW + 21;
    logic          pixelclk = 1'b0;
    logic          reset_n, i_mask, i_hsync, i_vsync, i_de;
    logic [CW-1:0] hcount_l, hcount_r, vcount_l, vcount_r;
    logic          box_valid, frame_done;
    logic [19:0]   pix_cnt;
    logic [OW-1:0] obs;
    int            n_checks = 0;
    int            n_fail = 0;
    int            m_x0, m_x1, m_y0, m_y1;
    bit            m_diag;

    target_box_detect #(.MIN_PIXELS(64), .CW(CW)) dut (
        .pixelclk(pixelclk), .reset_n(reset_n), .i_mask(i_mask), .i_hsync(i_hsync),
        .i_vsync(i_vsync), .i_de(i_de), .hcount_l(hcount_l), .hcount_r(hcount_r),
        .vcount_l(vcount_l), .vcount_r(vcount_r), .box_valid(box_valid),
        .pix_cnt(pix_cnt), .frame_done(frame_done)
    );

    always #5 pixelclk = ~pixelclk;
    assign obs = {hcount_l, hcount_r, vcount_l, vcount_r, box_valid, pix_cnt};

    function automatic logic [OW-1:0] box(int hl, int hr, int vl, int vr, int v, int p);
        return {CW'(hl), CW'(hr), CW'(vl), CW'(vr), 1'(v), 20'(p)};
    endfunction

    function automatic bit mask_at(int x, int y);
        return m_diag ? (x == y && x < 10) : (x >= m_x0 && x <= m_x1 && y >= m_y0 && y <= m_y1);
    endfunction

    task automatic tick();
        @(posedge pixelclk);
        #1;
    endtask

    task automatic set_rect(int x0, int x1, int y0, int y1);
        m_diag = 0; m_x0 = x0; m_x1 = x1; m_y0 = y0; m_y1 = y1;
    endtask

    task automatic send_lines(int w, int ys, int ye);
        for (int y = ys; y <= ye; y++) begin
            for (int x = 0; x < w; x++) begin
                i_de = 1'b1;
                i_mask = mask_at(x, y);
                tick();
            end
            i_de = 1'b0;
            i_mask = 1'b0;
            tick();
        end
    endtask

    task automatic vs_rise();
        i_vsync = 1'b1;
        tick();
    endtask

    task automatic vs_end();
        tick();
        i_vsync = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; i_mask = 0; i_hsync = 0; i_vsync = 0; i_de = 0;
        set_rect(0, 7, 0, 3);
        tick(); tick();
        n_checks++;
        if (obs !== '0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h fd=%b want 0 fd=0", obs, frame_done);
        end
        reset_n = 1'b1;
        tick();
        send_lines(8, 0, 3);
        vs_rise();
        n_checks++;
        if (obs !== '0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL first_frame_discard got %h fd=%b want 0 fd=0", obs, frame_done);
        end
        vs_end();
    endtask

    task automatic test_big_box();
        set_rect(100, 199, 50, 149);
        send_lines(320, 0, 239);
        vs_rise();
        n_checks++;
        if (obs !== box(100, 199, 50, 149, 1, 10000)) begin
            n_fail++;
            $display("FAIL big_box got %h want %h", obs, box(100, 199, 50, 149, 1, 10000));
        end
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL big_done_high got %b want 1", frame_done);
        end
        tick();
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL big_done_pulse got %b want 0", frame_done);
        end
        i_vsync = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        set_rect(4, 19, 2, 9);
        send_lines(32, 0, 7);
        n_checks++;
        if (obs !== box(100, 199, 50, 149, 1, 10000) || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_mid got %h fd=%b want %h fd=0", obs, frame_done, box(100, 199, 50, 149, 1, 10000));
        end
        send_lines(32, 8, 15);
        n_checks++;
        if (obs !== box(100, 199, 50, 149, 1, 10000)) begin
            n_fail++;
            $display("FAIL hold_end got %h want %h", obs, box(100, 199, 50, 149, 1, 10000));
        end
        vs_rise();
        n_checks++;
        if (obs !== box(4, 19, 2, 9, 1, 128) || frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL frame2_box got %h fd=%b want %h fd=1", obs, frame_done, box(4, 19, 2, 9, 1, 128));
        end
        vs_end();
    endtask

    task automatic test_scatter();
        m_diag = 1;
        send_lines(16, 0, 15);
        vs_rise();
        n_checks++;
        if (obs !== box(0, 0, 0, 0, 0, 10) || frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL scatter got %h fd=%b want %h fd=1", obs, frame_done, box(0, 0, 0, 0, 0, 10));
        end
        vs_end();
    endtask

    task automatic test_column();
        set_rect(40, 40, 0, 99);
        send_lines(48, 0, 99);
        vs_rise();
        n_checks++;
        if (obs !== box(0, 0, 0, 0, 0, 100)) begin
            n_fail++;
            $display("FAIL column got %h want %h", obs, box(0, 0, 0, 0, 0, 100));
        end
        vs_end();
    endtask

    task automatic test_coincident();
        set_rect(0, 15, 0, 7);
        send_lines(16, 0, 7);
        i_vsync = 1'b1; i_de = 1'b1; i_mask = 1'b1;
        tick();
        n_checks++;
        if (obs !== box(0, 15, 0, 7, 1, 128)) begin
            n_fail++;
            $display("FAIL coincident_close got %h want %h", obs, box(0, 15, 0, 7, 1, 128));
        end
        i_de = 1'b0; i_mask = 1'b0;
        vs_end();
        send_lines(16, 0, 7);
        vs_rise();
        n_checks++;
        if (pix_cnt !== 20'd128 || box_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL coincident_next got pix=%0d v=%b want pix=128 v=1", pix_cnt, box_valid);
        end
        vs_end();
    endtask

    task automatic test_reset_midframe();
        set_rect(4, 19, 2, 9);
        send_lines(32, 0, 3);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== '0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got %h fd=%b want 0 fd=0", obs, frame_done);
        end
        tick();
        reset_n = 1'b1;
        send_lines(32, 4, 15);
        vs_rise();
        n_checks++;
        if (obs !== '0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_discard got %h fd=%b want 0 fd=0", obs, frame_done);
        end
        vs_end();
        send_lines(32, 0, 15);
        vs_rise();
        n_checks++;
        if (obs !== box(4, 19, 2, 9, 1, 128) || frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset_box got %h fd=%b want %h fd=1", obs, frame_done, box(4, 19, 2, 9, 1, 128));
        end
        vs_end();
    endtask

    initial begin
        test_reset();
        test_big_box();
        test_back_to_back();
        test_scatter();
        test_column();
        test_coincident();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
